// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Full-add bit cell: two half adders chained, with their carries ORed together.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  halfAdder ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  halfAdder ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/halfAdder.sv
// Half adder: the basic sum/carry primitive reused by the full-add bit cell.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one result bit per clock, LSB first, through a
// single shared fa_cell. Optional subtract mode is enabled by defining the
// macro SERIAL_ADD_SUB_EN, which adds the sub input port.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry_reg;
  logic [CW-1:0]      cnt_reg;
  // Holds the WIDTH-1 result bits already produced; the last bit comes
  // straight from the cell on the edge that enters DONE.
  logic [WIDTH-2:0]   res_reg;

  logic               bit_sum;
  logic               bit_carry;
  logic [WIDTH-1:0]   res_shift;
  logic               sub_en;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  fa_cell u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .s    (bit_sum),
    .cout (bit_carry)
  );

  // New cell sum enters at the MSB side; everything else moves one place right.
  assign res_shift = {bit_sum, res_reg};

  // Sequencer: capture on accept, one bit per RUN edge, one-cycle DONE pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      res_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            a_reg     <= a;
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
            b_reg     <= sub_en ? ~b : b;
            carry_reg <= sub_en;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          res_reg   <= res_shift[WIDTH-1:1];
          carry_reg <= bit_carry;
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= res_shift;
            cout      <= bit_carry;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8. Subtract scenarios are
// compiled in only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic, {cout, sum}.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    if (s) return {(x >= y), 8'(x - y)};
    return 9'({1'b0, x} + {1'b0, y});
  endfunction

  // One full operation, called at a negedge; checks busy window, latency, result, hold.
  task automatic do_op(input logic [7:0] ea, input logic [7:0] eb, input logic es,
                       input bit disturb, input string tag);
    logic [8:0] exp;
    logic       s_eff;
`ifdef SERIAL_ADD_SUB_EN
    s_eff = es;
`else
    s_eff = 1'b0 & es;
`endif
    exp   = model(ea, eb, s_eff);
    a     = ea;
    b     = eb;
    sub   = s_eff;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, sum, cout} !== {1'b1, 1'b0, prev_sum, prev_cout}) begin
        n_err++;
        $display("FAIL %s run_cycle%0d: busy=%b done=%b sum=%h cout=%b, required busy=1 done=0 sum=%h cout=%b",
                 tag, k, busy, done, sum, cout, prev_sum, prev_cout);
      end
      if (disturb) begin
        a     = 8'($urandom);
        b     = 8'($urandom);
        sub   = 1'($urandom);
        start = (k % 2) == 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b1, exp[7:0], exp[8]}) begin
      n_err++;
      $display("FAIL %s done_cycle: busy=%b done=%b sum=%h cout=%b, required busy=0 done=1 sum=%h cout=%b",
               tag, busy, done, sum, cout, exp[7:0], exp[8]);
    end
    prev_sum  = exp[7:0];
    prev_cout = exp[8];
    @(negedge clk);
    n_vec++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, prev_sum, prev_cout}) begin
      n_err++;
      $display("FAIL %s idle_hold: busy=%b done=%b sum=%h cout=%b, required busy=0 done=0 sum=%h cout=%b",
               tag, busy, done, sum, cout, prev_sum, prev_cout);
    end
    $display("op %s a=%h b=%h sub=%b -> sum=%h cout=%b", tag, ea, eb, s_eff, sum, cout);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
    end
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    // Start on the very first edge after release.
    rst = 1'b0;
    do_op(8'hA7, 8'h2C, 1'b0, 1'b0, "first_after_reset");
  endtask

  task automatic test_basic();
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, "wrap_ff_01");
    do_op(8'h80, 8'h80, 1'b0, 1'b0, "wrap_80_80");
    do_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, "wrap_ff_ff");
  endtask

  task automatic test_isolation();
    do_op(8'h5C, 8'h91, 1'b0, 1'b1, "isolation");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      do_op(8'($urandom), 8'($urandom), 1'b0, bit'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_reset_abort();
    bit bad;
    do_op(8'hC3, 8'h5A, 1'b0, 1'b0, "pre_abort");
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      n_err++;
      $display("FAIL abort_async: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL abort_no_done: saw busy or done after reset release, required none");
    end
    do_op(8'h12, 8'h34, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int         t_done[$];
    exp   = model(8'h6B, 8'h3D, 1'b0);
    a     = 8'h6B;
    b     = 8'h3D;
    sub   = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t_done.push_back(i);
        n_vec++;
        if ({sum, cout} !== {exp[7:0], exp[8]}) begin
          n_err++;
          $display("FAIL b2b_result at cycle %0d: sum=%h cout=%b, required sum=%h cout=%b",
                   i, sum, cout, exp[7:0], exp[8]);
        end
      end
      if (i == 25) start = 1'b0;
    end
    n_vec++;
    if (t_done.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count: %0d done pulses, required 3", t_done.size());
    end else begin
      n_vec++;
      if (t_done[0] != 9 || t_done[1] - t_done[0] != 10 || t_done[2] - t_done[1] != 10) begin
        n_err++;
        $display("FAIL b2b_spacing: done at cycles %0d %0d %0d, required 9 19 29",
                 t_done[0], t_done[1], t_done[2]);
      end
    end
    prev_sum  = exp[7:0];
    prev_cout = exp[8];
    $display("op back_to_back a=6b b=3d -> %0d done pulses", t_done.size());
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    do_op(8'h10, 8'h03, 1'b1, 1'b0, "sub_10_03");
    do_op(8'h03, 8'h10, 1'b1, 1'b0, "sub_03_10");
    do_op(8'h55, 8'h55, 1'b1, 1'b0, "sub_equal");
    for (int i = 0; i < 8; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "sub_random");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_isolation();
    test_random();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition, sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the edge that accepts start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-008 The block SHALL have port sum, output, WIDTH bits: result, registered.
REQ-009 The block SHALL have port cout, output, 1 bit: final carry, registered.

Function
REQ-010 The block SHALL compute a+b bit-serially, LSB first, one bit per clock, using a single shared full-add bit cell.
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL go to RUN on the next edge; on that edge the block SHALL load a and b into shift registers, clear the carry flop and clear the bit counter.
REQ-013 In RUN, each edge SHALL:
- shift the bit-cell sum into the result register MSB-side, right-shifting the register;
- store the carry-out into the carry flop;
- right-shift both operand registers;
- increment the counter.
REQ-014 RUN SHALL last exactly WIDTH cycles; when the counter reaches WIDTH-1, the next edge SHALL go to DONE.
REQ-015 DONE SHALL last one cycle, then go unconditionally to IDLE.
REQ-016 Latency SHALL be fixed: done is high in the cycle following the (WIDTH+1)th rising edge counted from, and including, the accept edge.
REQ-017 sum and cout SHALL update only on entry to DONE, and SHALL hold until the next DONE entry.
REQ-018 start SHALL be ignored in RUN and DONE; no queuing.
REQ-019 A start held high continuously SHALL cause back-to-back operations, with one IDLE cycle between DONE and the next RUN.
REQ-020 a and b changing during RUN SHALL NOT affect the result in progress.
REQ-021 Carry SHALL wrap naturally: the sum is modulo 2^WIDTH and cout is the carry out of the MSB.

Reset
REQ-022 rst=1 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-023 Reset SHALL clear busy, done, sum, cout, the counter, the carry flop and the operand registers to 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow the release of reset.
REQ-025 The first start SHALL be honoured on the first edge after rst deasserts.

Configuration
REQ-026 With macro SERIAL_ADD_SUB_EN defined, the block SHALL add input port sub (1 bit), captured with the operands.
REQ-027 With sub=1, the block SHALL:
- invert b on capture;
- preset the carry flop to 1;
- produce sum = a-b mod 2^WIDTH;
- produce cout = 1 when a >= b (unsigned, no borrow).
REQ-028 Without SERIAL_ADD_SUB_EN, port sub SHALL be absent and behaviour SHALL be addition only, identical to sub=0.

Structure
REQ-029 A shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-030 The bit cell SHALL be one sub-module, fa_cell: a full adder built from two existing halfAdder instances plus an OR of their carries.
REQ-031 All sequencing SHALL live in serial_add_ctrl.

Verification (WIDTH=8)
REQ-032 Basic add: a=0x35, b=0x4A, start pulse -> busy high for 8 cycles, then done for 1 cycle, sum=0x7F, cout=0.
REQ-033 Carry chain and wrap: a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0x80, b=0x80 -> sum=0x00, cout=1.
REQ-034 Operand and start isolation: change a/b and pulse start during RUN -> result still from the captured operands, no extra done.
REQ-035 Reset abort: assert rst at RUN cycle 4 -> busy, done, sum and cout go to 0 immediately; no done afterwards.
REQ-036 Back-to-back: hold start high for 25 cycles -> done pulses exactly 10 cycles apart, with a constant result.
REQ-037 With SERIAL_ADD_SUB_EN: a=0x10, b=0x03, sub=1 -> sum=0x0D, cout=1; a=0x03, b=0x10, sub=1 -> sum=0xF3, cout=0.
